axi_stream_remove_header: RTL and testbench
===========================================

# axi_stream_remove_header

Strips a per-packet number of leading bytes from an AXI-Stream packet and re-aligns the remaining payload to full-width beats. It is the downstream counterpart of `axi_stream_insert_header`: it consumes a header-prefixed stream and hands the bare payload to the next stage. The byte count is delivered once per packet on a command handshake. Full throughput is one beat per cycle with registered outputs.

## Interface
- `DATA_WD`, default 32: data width in bits.
- `DATA_BYTE_WD`, default `DATA_WD/8`: number of bytes per beat.
- `BYTE_CNT_WD`, default `$clog2(DATA_BYTE_WD)`: width of the remove count.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `valid_in`, in, 1: input beat valid.
- `data_in`, in, `DATA_WD`: input beat data. Byte `[DATA_WD-1 -: 8]` is first on the wire.
- `keep_in`, in, `DATA_BYTE_WD`: input byte enables. All ones on non-last beats. Left-aligned and nonzero on the last beat.
- `last_in`, in, 1: marks the final beat of the packet.
- `ready_in`, out, 1: input beat accepted when high together with `valid_in`.
- `valid_remove`, in, 1: command valid.
- `byte_remove_cnt`, in, `BYTE_CNT_WD`: number R of leading bytes to drop, range 0..`DATA_BYTE_WD`-1.
- `ready_remove`, out, 1: command accepted when high together with `valid_remove`.
- `valid_out`, `data_out`, `keep_out`, `last_out`, out, 1/`DATA_WD`/`DATA_BYTE_WD`/1: output stream. `keep_out` is always left-aligned.
- `ready_out`, in, 1: downstream ready.

## Operation
The block is an FSM with states IDLE, FIRST, STREAM and FLUSH. It has a holding register `hold` and a count `hcnt` of valid bytes in `hold`.

- **IDLE**
  - `ready_remove`=1 and `ready_in`=0.
  - On command handshake: latch R and go to FIRST.
- **FIRST**
  - `ready_in` = `!valid_out || ready_out`. This rule also applies in STREAM.
  - On an accepted non-last beat: `hold` = the beat shifted left by 8R bits, `hcnt` = `DATA_BYTE_WD`-R. Go to STREAM.
  - On an accepted last beat with k valid bytes:
    - If k ≤ R: emit no output and return to IDLE.
    - Otherwise: emit one beat (data shifted by R, keep covering k-R bytes, last=1) and go to IDLE.
- **STREAM**
  - An accepted beat with k bytes is merged into `hold`: output = `hold`'s `hcnt` bytes followed by the beat's first `DATA_BYTE_WD`-`hcnt` bytes. The beat's remaining bytes become the new `hold`.
  - Last beat with `hcnt`+k ≤ `DATA_BYTE_WD`: emit a single merged beat with keep covering `hcnt`+k bytes and last=1. Go to IDLE.
  - Last beat with `hcnt`+k > `DATA_BYTE_WD`: emit a full beat with last=0, keep the residue of `hcnt`+k-`DATA_BYTE_WD` bytes, and go to FLUSH.
- **FLUSH**
  - `ready_in`=0.
  - When the output slot is free, emit the residue with last=1 and go to IDLE.
- R=0 uses the same path with no special case.
- Zero-filled bytes: any byte of `data_out` outside `keep_out` is 0.
- Input beats presented in IDLE are not accepted.

## Timing
- Reset values: `valid_out`=0, `data_out`=0, `keep_out`=0, `last_out`=0, `ready_in`=0, `ready_remove`=1. State = IDLE, `hold`=0, `hcnt`=0.
- All stream outputs are registered. `ready_in` and `ready_remove` are combinational from state and the output register only, never from `valid_in`.
- Output beat n is presented on the edge that accepts input beat n+1. The exception is a single-beat packet, whose only output beat is presented on the edge that accepts it.
- After the last output beat is loaded, the FSM is in IDLE on the same edge, so `ready_remove`=1 on the next cycle.
- The output register holds `data_out`, `keep_out` and `last_out` stable while `valid_out && !ready_out`.
- When the output register is loaded and consumed in the same cycle, there is no bubble.
- Asserting `rst` mid-packet returns the block to reset values on the next edge. The partial packet is discarded, and the upstream source restarts at a packet boundary.

## Structure
- Shared package `axi_stream_pkg`:
  - the FSM state enum;
  - function `keep_from_cnt(n)`, returning a left-aligned mask;
  - function `keep_popcount`.
- Sub-module `axi_stream_byte_merge`: combinational. Inputs are `hold`, `hcnt` and the input beat. Outputs are the merged data/keep and the next `hold`/`hcnt`.
- The top level contains the FSM, the output register and the command latch.

## Test plan
1. **R=2, three-beat packet.**
   - Stimulus: `01020304`, `05060708`, `090A0B0C` (keep 1111, last).
   - Required output: `03040506`, `0708090A`, then `0B0C0000` with keep 1100 and last=1.
2. **R=1, two-beat packet.**
   - Stimulus: `01020304`, then `05060708` with keep 1000 and last.
   - Required output: a single beat `02030405` with keep 1111 and last=1.
3. **R=0, two-beat packet.**
   - Stimulus: `11223344`, then `55667788` with keep 1110 and last.
   - Required output: `11223344`, then `55667700` with keep 1110 and last=1. Payload is unchanged.
4. **R=3, single-beat packet.**
   - Stimulus: `AABBCCDD` with keep 1100 and last.
   - Required response: no output beat, and `ready_remove`=1 on the next cycle.
5. **Backpressure.** Run scenario 1 with `ready_out`=0 for 5 cycles after the first output beat.
   - `data_out` stays at `03040506` and `valid_out` stays at 1.
   - `ready_in`=0 for those cycles.
   - The final output matches scenario 1 with no lost or duplicated bytes.
6. **Mid-packet reset.** Assert `rst` for one cycle after the second beat of scenario 1.
   - All outputs take their reset values on the next edge.
   - A fresh scenario-2 packet then produces `02030405`.

Source files
------------

// File: rtl/axi_stream_pkg.sv
// Shared types and helpers for the AXI-Stream header insert/remove blocks.
package axi_stream_pkg;

    // FSM states of the header remover
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_STREAM = 2'd2,
        ST_FLUSH  = 2'd3
    } rm_state_t;

    // Widest beat (in bytes) the helpers below can describe, and the width
    // of byte counts that travel through them.
    localparam int MAX_BYTES = 64;
    localparam int CNT_WD    = 7;

    // Left-aligned byte mask of a `width`-byte beat with the first `n` bytes
    // set. Bit width-1 is the first byte on the wire. n >= width gives all
    // ones across the beat.
    function automatic logic [MAX_BYTES-1:0] keep_from_cnt(
        input logic [CNT_WD-1:0] n,
        input logic [CNT_WD-1:0] width
    );
        logic [MAX_BYTES-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if ((i < int'(width)) && (i >= int'(width) - int'(n))) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

    // Number of set bits in a byte-enable vector.
    function automatic logic [CNT_WD-1:0] keep_popcount(
        input logic [MAX_BYTES-1:0] keep
    );
        logic [CNT_WD-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            cnt = cnt + CNT_WD'(keep[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axi_stream_byte_merge.sv
// Combinational byte merger: appends the leading bytes of an input beat to
// the bytes already waiting in the holding register and returns what is
// left of the beat as the next holding value.
module axi_stream_byte_merge
    import axi_stream_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int HCNT_WD      = $clog2(DATA_BYTE_WD + 1)
) (
    input  logic [DATA_WD-1:0]      hold,
    input  logic [HCNT_WD-1:0]      hcnt,
    input  logic [DATA_WD-1:0]      beat_data,
    input  logic [DATA_BYTE_WD-1:0] beat_keep,
    output logic [DATA_WD-1:0]      beat_masked,
    output logic [CNT_WD-1:0]       beat_cnt,
    output logic [DATA_WD-1:0]      merged_data,
    output logic [DATA_BYTE_WD-1:0] merged_keep,
    output logic [DATA_WD-1:0]      next_hold,
    output logic [HCNT_WD-1:0]      next_hcnt,
    output logic                    overflow
);

    logic [CNT_WD-1:0]    total;
    logic [MAX_BYTES-1:0] keep_full;
    logic                 unused_keep_bits;

    // Zero every byte the beat does not claim, so bytes outside keep_out
    // always come out as zero.
    always_comb begin
        beat_masked = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            beat_masked[8*i +: 8] = beat_data[8*i +: 8] & {8{beat_keep[i]}};
        end
    end

    assign beat_cnt  = keep_popcount(MAX_BYTES'(beat_keep));
    assign total     = CNT_WD'(hcnt) + beat_cnt;
    assign overflow  = total > CNT_WD'(DATA_BYTE_WD);
    assign keep_full = keep_from_cnt(total, CNT_WD'(DATA_BYTE_WD));
    assign unused_keep_bits = ^keep_full[MAX_BYTES-1:DATA_BYTE_WD];

    // Held bytes sit left-aligned with zeros below them, so the beat can be
    // OR-ed in right behind them. With hcnt equal to a full beat the shift
    // pushes the whole beat out and it all becomes the next hold.
    assign merged_data = hold | (beat_masked >> {hcnt, 3'b000});
    assign merged_keep = keep_full[DATA_BYTE_WD-1:0];
    assign next_hold   = beat_masked << {(HCNT_WD'(DATA_BYTE_WD) - hcnt), 3'b000};
    assign next_hcnt   = overflow ? HCNT_WD'(total - CNT_WD'(DATA_BYTE_WD)) : '0;

endmodule

// File: rtl/axi_stream_remove_header.sv
// Drops R leading bytes from each AXI-Stream packet and re-packs the rest
// of the payload into full-width beats. R arrives once per packet on a
// command handshake. The output stage is a single register slot.
module axi_stream_remove_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic                    valid_remove,
    input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
    output logic                    ready_remove,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out
);
    import axi_stream_pkg::*;

    localparam int HCNT_WD = $clog2(DATA_BYTE_WD + 1);

    rm_state_t                state_q, state_d;
    logic [BYTE_CNT_WD-1:0]   rcnt_q, rcnt_d;
    logic [DATA_WD-1:0]       hold_q, hold_d;
    logic [HCNT_WD-1:0]       hcnt_q, hcnt_d;

    logic                     valid_d;
    logic [DATA_WD-1:0]       data_d;
    logic [DATA_BYTE_WD-1:0]  keep_d;
    logic                     last_d;

    logic                     out_free;
    logic                     accept;

    logic [DATA_WD-1:0]       beat_masked;
    logic [CNT_WD-1:0]        beat_cnt;
    logic [DATA_WD-1:0]       merged_data;
    logic [DATA_BYTE_WD-1:0]  merged_keep;
    logic [DATA_WD-1:0]       next_hold;
    logic [HCNT_WD-1:0]       next_hcnt;
    logic                     overflow;

    logic [DATA_WD-1:0]       first_data;
    logic [MAX_BYTES-1:0]     first_keep_full;
    logic [MAX_BYTES-1:0]     flush_keep_full;
    logic                     unused_keep_bits;

    axi_stream_byte_merge #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .HCNT_WD      (HCNT_WD)
    ) u_merge (
        .hold        (hold_q),
        .hcnt        (hcnt_q),
        .beat_data   (data_in),
        .beat_keep   (keep_in),
        .beat_masked (beat_masked),
        .beat_cnt    (beat_cnt),
        .merged_data (merged_data),
        .merged_keep (merged_keep),
        .next_hold   (next_hold),
        .next_hcnt   (next_hcnt),
        .overflow    (overflow)
    );

    // The output slot can take a new beat when it is empty or being drained.
    assign out_free     = !valid_out || ready_out;
    assign ready_in     = ((state_q == ST_FIRST) || (state_q == ST_STREAM)) && out_free;
    assign ready_remove = (state_q == ST_IDLE);
    assign accept       = valid_in && ready_in;

    // The first beat of a packet loses its R leading bytes; what remains is
    // already left-aligned and zero-filled behind.
    assign first_data      = beat_masked << {rcnt_q, 3'b000};
    assign first_keep_full = keep_from_cnt(beat_cnt - CNT_WD'(rcnt_q), CNT_WD'(DATA_BYTE_WD));
    assign flush_keep_full = keep_from_cnt(CNT_WD'(hcnt_q), CNT_WD'(DATA_BYTE_WD));
    assign unused_keep_bits = ^{first_keep_full[MAX_BYTES-1:DATA_BYTE_WD],
                                flush_keep_full[MAX_BYTES-1:DATA_BYTE_WD]};

    // Next-state, holding register and output slot update.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        hold_d  = hold_q;
        hcnt_d  = hcnt_q;
        valid_d = valid_out && !ready_out;
        data_d  = data_out;
        keep_d  = keep_out;
        last_d  = last_out;

        case (state_q)
            ST_IDLE: begin
                if (valid_remove) begin
                    rcnt_d  = byte_remove_cnt;
                    state_d = ST_FIRST;
                end
            end

            ST_FIRST: begin
                if (accept) begin
                    if (!last_in) begin
                        hold_d  = first_data;
                        hcnt_d  = HCNT_WD'(DATA_BYTE_WD) - HCNT_WD'(rcnt_q);
                        state_d = ST_STREAM;
                    end else begin
                        // A packet no longer than its header yields nothing.
                        if (beat_cnt > CNT_WD'(rcnt_q)) begin
                            valid_d = 1'b1;
                            data_d  = first_data;
                            keep_d  = first_keep_full[DATA_BYTE_WD-1:0];
                            last_d  = 1'b1;
                        end
                        hold_d  = '0;
                        hcnt_d  = '0;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_STREAM: begin
                if (accept) begin
                    valid_d = 1'b1;
                    data_d  = merged_data;
                    keep_d  = merged_keep;
                    last_d  = last_in && !overflow;
                    if (!last_in || overflow) begin
                        hold_d = next_hold;
                        hcnt_d = next_hcnt;
                    end else begin
                        hold_d = '0;
                        hcnt_d = '0;
                    end
                    if (last_in) begin
                        state_d = overflow ? ST_FLUSH : ST_IDLE;
                    end
                end
            end

            ST_FLUSH: begin
                if (out_free) begin
                    valid_d = 1'b1;
                    data_d  = hold_q;
                    keep_d  = flush_keep_full[DATA_BYTE_WD-1:0];
                    last_d  = 1'b1;
                    hold_d  = '0;
                    hcnt_d  = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch, holding register and registered output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt_q    <= '0;
            hold_q    <= '0;
            hcnt_q    <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else begin
            rcnt_q    <= rcnt_d;
            hold_q    <= hold_d;
            hcnt_q    <= hcnt_d;
            valid_out <= valid_d;
            data_out  <= data_d;
            keep_out  <= keep_d;
            last_out  <= last_d;
        end
    end

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Directed bench for axi_stream_remove_header with hand-computed results.
module tb_axi_stream_remove_header;

    localparam int DATA_WD      = 32;
    localparam int DATA_BYTE_WD = 4;
    localparam int BYTE_CNT_WD  = 2;
    localparam int WAIT_LIMIT   = 50;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;
    logic                    valid_remove;
    logic [BYTE_CNT_WD-1:0]  byte_remove_cnt;
    logic                    ready_remove;
    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;

    int total_checks  = 0;
    int passed_checks = 0;
    int failed_checks = 0;

    logic [36:0] out_q[$];

    axi_stream_remove_header #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .BYTE_CNT_WD  (BYTE_CNT_WD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_in        (valid_in),
        .data_in         (data_in),
        .keep_in         (keep_in),
        .last_in         (last_in),
        .ready_in        (ready_in),
        .valid_remove    (valid_remove),
        .byte_remove_cnt (byte_remove_cnt),
        .ready_remove    (ready_remove),
        .valid_out       (valid_out),
        .data_out        (data_out),
        .keep_out        (keep_out),
        .last_out        (last_out),
        .ready_out       (ready_out)
    );

    always #5 clk = ~clk;

    // Record every beat the downstream side actually takes.
    always @(posedge clk) begin
        if (!rst && valid_out && ready_out) begin
            out_q.push_back({data_out, keep_out, last_out});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else begin
            failed_checks++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ent(input logic [31:0] d, input logic [3:0] k, input logic l);
        return {27'b0, d, k, l};
    endfunction

    task automatic send_cmd(input logic [1:0] r);
        int n;
        n = 0;
        @(negedge clk);
        valid_remove    = 1'b1;
        byte_remove_cnt = r;
        while (!ready_remove && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("cmd_wait", 64'(n < WAIT_LIMIT), 64'(1));
        @(posedge clk);
        #1;
        valid_remove = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        while (!ready_in && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("beat_wait", 64'(n < WAIT_LIMIT), 64'(1));
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        valid_in        = 1'b0;
        data_in         = '0;
        keep_in         = '0;
        last_in         = 1'b0;
        valid_remove    = 1'b0;
        byte_remove_cnt = '0;
        ready_out       = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_out",    64'(valid_out),    64'(0));
        check("rst_data_out",     64'(data_out),     64'(0));
        check("rst_keep_out",     64'(keep_out),     64'(0));
        check("rst_last_out",     64'(last_out),     64'(0));
        check("rst_ready_in",     64'(ready_in),     64'(0));
        check("rst_ready_remove", 64'(ready_remove), 64'(1));
        @(negedge clk);
        rst = 1'b0;

        // A beat offered in IDLE is never taken
        valid_in = 1'b1;
        data_in  = 32'hDEADBEEF;
        keep_in  = 4'hF;
        last_in  = 1'b1;
        @(negedge clk);
        check("idle_ready_in", 64'(ready_in), 64'(0));
        @(posedge clk);
        #1;
        check("idle_no_output", 64'(valid_out), 64'(0));
        valid_in = 1'b0;
        last_in  = 1'b0;

        // Scenario 1: R=2, three full beats
        out_q.delete();
        send_cmd(2'd2);
        send_beat(32'h01020304, 4'hF, 1'b0);
        check("s1_no_out_after_first", 64'(valid_out), 64'(0));
        send_beat(32'h05060708, 4'hF, 1'b0);
        check("s1_first_out_timing", 64'(data_out), 64'h03040506);
        send_beat(32'h090A0B0C, 4'hF, 1'b1);
        repeat (4) @(negedge clk);
        check("s1_count", 64'(out_q.size()), 64'(3));
        check("s1_b0", 64'(out_q[0]), ent(32'h03040506, 4'hF, 1'b0));
        check("s1_b1", 64'(out_q[1]), ent(32'h0708090A, 4'hF, 1'b0));
        check("s1_b2", 64'(out_q[2]), ent(32'h0B0C0000, 4'hC, 1'b1));
        check("s1_ready_remove", 64'(ready_remove), 64'(1));

        // Scenario 2: R=1, last beat carries one byte, single output beat
        out_q.delete();
        send_cmd(2'd1);
        send_beat(32'h01020304, 4'hF, 1'b0);
        send_beat(32'h05060708, 4'h8, 1'b1);
        check("s2_valid_now",        64'(valid_out),    64'(1));
        check("s2_data_now",         64'(data_out),     64'h02030405);
        check("s2_keep_now",         64'(keep_out),     64'hF);
        check("s2_last_now",         64'(last_out),     64'(1));
        check("s2_ready_remove_now", 64'(ready_remove), 64'(1));
        repeat (3) @(negedge clk);
        check("s2_count", 64'(out_q.size()), 64'(1));
        check("s2_b0", 64'(out_q[0]), ent(32'h02030405, 4'hF, 1'b1));

        // Scenario 3: R=0, payload passes through unchanged
        out_q.delete();
        send_cmd(2'd0);
        send_beat(32'h11223344, 4'hF, 1'b0);
        send_beat(32'h55667788, 4'hE, 1'b1);
        repeat (4) @(negedge clk);
        check("s3_count", 64'(out_q.size()), 64'(2));
        check("s3_b0", 64'(out_q[0]), ent(32'h11223344, 4'hF, 1'b0));
        check("s3_b1", 64'(out_q[1]), ent(32'h55667700, 4'hE, 1'b1));

        // Scenario 4: R=3, single beat of two bytes produces nothing
        out_q.delete();
        send_cmd(2'd3);
        send_beat(32'hAABBCCDD, 4'hC, 1'b1);
        check("s4_no_valid",     64'(valid_out),    64'(0));
        check("s4_ready_remove", 64'(ready_remove), 64'(1));
        repeat (3) @(negedge clk);
        check("s4_count", 64'(out_q.size()), 64'(0));

        // Scenario 5: scenario 1 with downstream stalled after the first output
        out_q.delete();
        send_cmd(2'd2);
        send_beat(32'h01020304, 4'hF, 1'b0);
        send_beat(32'h05060708, 4'hF, 1'b0);
        ready_out = 1'b0;
        valid_in  = 1'b1;
        data_in   = 32'h090A0B0C;
        keep_in   = 4'hF;
        last_in   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s5_hold_valid", 64'(valid_out), 64'(1));
            check("s5_hold_data",  64'(data_out),  64'h03040506);
            check("s5_ready_in",   64'(ready_in),  64'(0));
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
        ready_out = 1'b1;
        send_beat(32'h090A0B0C, 4'hF, 1'b1);
        repeat (4) @(negedge clk);
        check("s5_count", 64'(out_q.size()), 64'(3));
        check("s5_b0", 64'(out_q[0]), ent(32'h03040506, 4'hF, 1'b0));
        check("s5_b1", 64'(out_q[1]), ent(32'h0708090A, 4'hF, 1'b0));
        check("s5_b2", 64'(out_q[2]), ent(32'h0B0C0000, 4'hC, 1'b1));

        // Scenario 6: reset in the middle of a scenario-1 packet
        send_cmd(2'd2);
        send_beat(32'h01020304, 4'hF, 1'b0);
        send_beat(32'h05060708, 4'hF, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("s6_valid_out",    64'(valid_out),    64'(0));
        check("s6_data_out",     64'(data_out),     64'(0));
        check("s6_keep_out",     64'(keep_out),     64'(0));
        check("s6_last_out",     64'(last_out),     64'(0));
        check("s6_ready_in",     64'(ready_in),     64'(0));
        check("s6_ready_remove", 64'(ready_remove), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        out_q.delete();
        send_cmd(2'd1);
        send_beat(32'h01020304, 4'hF, 1'b0);
        send_beat(32'h05060708, 4'h8, 1'b1);
        repeat (3) @(negedge clk);
        check("s6_count", 64'(out_q.size()), 64'(1));
        check("s6_b0", 64'(out_q[0]), ent(32'h02030405, 4'hF, 1'b1));

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
